// File: rtl/bcp_pkg.sv
// Shared types and parameter defaults for the BCP implication generator.
package bcp_pkg;

  localparam int NLIT_DEF = 4;
  localparam int VW_DEF   = 8;
  localparam int CIDW_DEF = 8;
  localparam int FD_DEF   = 4;

  typedef enum logic [1:0] {SAT, UNIT, CONFL, OPEN} clause_cls_e;

  typedef enum logic {RUN, HALT} state_e;

endpackage

// File: rtl/bcp_imp_fifo.sv
// Implication FIFO: power-of-two depth, simultaneous push/pop at any occupancy.
module bcp_imp_fifo
  import bcp_pkg::*;
#(
  parameter int W  = 8,
  parameter int FD = FD_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [W-1:0]          push_data,
  input  logic                  pop,
  output logic [W-1:0]          pop_data,
  output logic                  not_empty,
  output logic [$clog2(FD):0]   count
);

  localparam int AW = $clog2(FD);

  logic [W-1:0]  mem [FD];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign do_pop    = pop && (cnt != '0);
  // A push into a full FIFO is legal only when the head leaves at the same edge.
  assign do_push   = push && ((cnt != (AW+1)'(FD)) || do_pop);
  assign not_empty = (cnt != '0);
  assign count     = cnt;
  assign pop_data  = not_empty ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // NOTE: storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bcp_imply_gen.sv
// Classifies clause words (SAT/UNIT/CONFL/OPEN), queues unit implications,
// and halts on the first conflict until released.
module bcp_imply_gen
  import bcp_pkg::*;
#(
  parameter int NLIT = NLIT_DEF,
  parameter int VW   = VW_DEF,
  parameter int CIDW = CIDW_DEF,
  parameter int FD   = FD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CIDW-1:0]   in_cid,
  input  logic [NLIT-1:0]   in_mask,
  input  logic [NLIT-1:0]   in_pol,
  input  logic [NLIT-1:0]   in_asgn,
  input  logic [NLIT-1:0]   in_val,
  input  logic [NLIT*VW-1:0] in_var,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VW-1:0]     out_var,
  output logic              out_val,
  output logic [CIDW-1:0]   out_cid,
  output logic              conflict,
  output logic [CIDW-1:0]   conflict_cid,
  input  logic              conflict_clr,
  output logic              busy,
  output logic [15:0]       imp_count
);

  localparam int CW = $clog2(FD) + 1;
  localparam int DW = VW + 1 + CIDW;

  state_e state_q, state_d;

  logic               s1_valid;
  logic [CIDW-1:0]    s1_cid;
  logic [NLIT-1:0]    s1_mask, s1_pol, s1_asgn, s1_val;
  logic [NLIT*VW-1:0] s1_var;

  logic [NLIT-1:0] true_v, open_v;
  logic            one_open;
  logic [VW-1:0]   unit_var;
  logic            unit_pol;
  clause_cls_e     cls;

  logic            accept, conflict_det, push, out_fire;
  logic [DW-1:0]   fifo_q;
  logic            fifo_ne;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     occ;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    true_v   = '0;
    open_v   = '0;
    unit_var = '0;
    unit_pol = 1'b0;
    for (int k = 0; k < NLIT; k++) begin
      true_v[k] = s1_mask[k] & s1_asgn[k] & (s1_val[k] == s1_pol[k]);
      open_v[k] = s1_mask[k] & ~s1_asgn[k];
      if (open_v[k]) begin
        unit_var = s1_var[k*VW +: VW];
        unit_pol = s1_pol[k];
      end
    end
    one_open = (open_v != '0) && ((open_v & (open_v - 1'b1)) == '0);

    // An empty clause would otherwise look like a conflict.
    if (s1_mask == '0)       cls = SAT;
    else if (true_v != '0)   cls = SAT;
    else if (open_v == '0)   cls = CONFL;
    else if (one_open)       cls = UNIT;
    else                     cls = OPEN;
  end

  assign conflict_det = s1_valid && (cls == CONFL);
  assign push         = s1_valid && (cls == UNIT);

  // Occupancy counts the clause in S1, so a UNIT push always has room.
  assign occ      = {1'b0, fifo_count} + {{CW{1'b0}}, s1_valid};
  assign in_ready = (state_q == RUN) && (occ < (CW+1)'(FD));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    if (conflict_det)                            state_d = HALT;
    else if ((state_q == HALT) && conflict_clr)  state_d = RUN;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst || conflict_det) s1_valid <= 1'b0;
    else                     s1_valid <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_cid  <= in_cid;
      s1_mask <= in_mask;
      s1_pol  <= in_pol;
      s1_asgn <= in_asgn;
      s1_val  <= in_val;
      s1_var  <= in_var;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)               conflict_cid <= '0;
    else if (conflict_det) conflict_cid <= s1_cid;
  end

  always_ff @(posedge clk) begin
    if (rst)                                   imp_count <= '0;
    else if (out_fire && (imp_count != 16'hFFFF)) imp_count <= imp_count + 16'd1;
  end

  bcp_imp_fifo #(.W(DW), .FD(FD)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (conflict_det),
    .push      (push),
    .push_data ({unit_var, unit_pol, s1_cid}),
    .pop       (out_fire),
    .pop_data  (fifo_q),
    .not_empty (fifo_ne),
    .count     (fifo_count)
  );

  assign out_valid = (state_q == RUN) && fifo_ne;
  assign out_fire  = out_valid && out_ready;
  assign out_var   = fifo_q[DW-1 -: VW];
  assign out_val   = fifo_q[CIDW];
  assign out_cid   = fifo_q[CIDW-1:0];
  assign conflict  = (state_q == HALT);
  assign busy      = s1_valid || fifo_ne;

endmodule
